pattern_vec_driver: RTL and testbench



---
 rtl/pattern_drv_pkg.sv | 26 ++
 rtl/pattern_misr.sv | 35 +++
 rtl/pattern_vec_driver.sv | 139 +++++++++++++
 tb/tb_pattern_vec_driver.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pattern_drv_pkg.sv
// Shared types and constants for the pattern stimulus/compaction front end.
// Width defaults, the LFSR/MISR polynomials, FSM state encoding and the LFSR step.
package pattern_drv_pkg;

  localparam int VEC_W     = 11;
  localparam int RSP_W     = 8;
  localparam int SIG_W     = 16;
  localparam int CNT_W     = 16;
  localparam int DRAIN_CYC = 2;

  localparam logic [VEC_W-1:0] LFSR_TAPS = 11'h500;
  localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } drv_state_e;

  // Fibonacci step for x^11+x^9+1: feedback is q[10]^q[8].
  function automatic logic [VEC_W-1:0] lfsr_next(input logic [VEC_W-1:0] q);
    return {q[VEC_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pattern_misr.sv
// 16-bit MISR compacting the response bus; one update per enabled cycle.
// Synchronous clear wins over enable; asynchronous active-low reset.
module pattern_misr
  import pattern_drv_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [RSP_W-1:0] i_dat,
  output logic [SIG_W-1:0] o_sig
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_sig_next;

  always_comb begin
    w_sig_next = {r_sig[SIG_W-2:0], 1'b0}
               ^ (r_sig[SIG_W-1] ? MISR_POLY : '0)
               ^ {{(SIG_W-RSP_W){1'b0}}, i_dat};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sig <= '0;
    end else if (i_clr) begin
      r_sig <= '0;
    end else if (i_en) begin
      r_sig <= w_sig_next;
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/pattern_vec_driver.sv
// LFSR vector driver + MISR response compactor for merged pattern netlists.
// Optional PATTERN_DRV_ABORT_EN adds an abort input that ends a run early.
module pattern_vec_driver
  import pattern_drv_pkg::*;
(
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             start,
  input  logic [VEC_W-1:0] seed,
  input  logic [CNT_W-1:0] num_vec,
`ifdef PATTERN_DRV_ABORT_EN
  input  logic             abort,
`endif
  output logic [VEC_W-1:0] vec_out,
  output logic             vec_valid,
  input  logic [RSP_W-1:0] rsp_in,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] vec_count
);

  localparam int DCW = $clog2(DRAIN_CYC) + 1;

  drv_state_e           r_state;
  logic [VEC_W-1:0]     r_lfsr;
  logic [CNT_W-1:0]     r_num_vec;
  logic [CNT_W-1:0]     r_vec_count;
  logic [DCW-1:0]       r_drain_cnt;
  logic [VEC_W-1:0]     r_vec_out;
  logic                 r_vec_valid;
  logic                 r_busy;
  logic                 r_done;
  logic [DRAIN_CYC-1:0] r_cap;

  logic w_abort;
  logic w_accept;
  logic w_issue;

`ifdef PATTERN_DRV_ABORT_EN
  assign w_abort = abort & r_busy;
`else
  assign w_abort = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) && start;
  assign w_issue  = (r_state == RUN) && !w_abort;

  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      r_state     <= IDLE;
      r_lfsr      <= '0;
      r_num_vec   <= '0;
      r_vec_count <= '0;
      r_drain_cnt <= '0;
      r_vec_out   <= '0;
      r_vec_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_num_vec   <= num_vec;
            r_lfsr      <= (seed == '0) ? VEC_W'(1) : seed;
            r_vec_count <= '0;
            if (num_vec == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_abort) begin
            r_state     <= DONE;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_vec_out   <= '0;
            r_vec_valid <= 1'b0;
          end else begin
            r_vec_out   <= r_lfsr;
            r_vec_valid <= 1'b1;
            r_lfsr      <= lfsr_next(r_lfsr);
            r_vec_count <= r_vec_count + 1'b1;
            if (r_vec_count + 1'b1 == r_num_vec) begin
              r_state     <= DRAIN;
              r_drain_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          r_vec_out   <= '0;
          r_vec_valid <= 1'b0;
          r_drain_cnt <= r_drain_cnt + 1'b1;
          if (w_abort || r_drain_cnt == DCW'(DRAIN_CYC - 1)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Capture pipe tracks issued vectors so the MISR samples each response
  // DRAIN_CYC edges after its vector; flushed on start and abort.
  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      r_cap <= '0;
    end else if (w_accept || w_abort) begin
      r_cap <= '0;
    end else begin
      r_cap <= (r_cap << 1) | DRAIN_CYC'(w_issue);
    end
  end

  pattern_misr u_misr (
    .i_clk   (blif_clk_net),
    .i_rst_n (blif_reset_net),
    .i_clr   (w_accept),
    .i_en    (r_cap[DRAIN_CYC-1]),
    .i_dat   (rsp_in),
    .o_sig   (signature)
  );

  assign vec_out   = r_vec_out;
  assign vec_valid = r_vec_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign vec_count = r_vec_count;

endmodule

// File: tb/tb_pattern_vec_driver.sv
// Directed self-checking bench for pattern_vec_driver (abort cases when PATTERN_DRV_ABORT_EN).
module tb_pattern_vec_driver;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [10:0] seed;
  logic [15:0] num_vec;
  logic        abort;
  logic [10:0] vec_out;
  logic        vec_valid;
  logic [7:0]  rsp_in;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic [15:0] vec_count;

  int n_chk;
  int n_fail;

  logic [10:0] vecs[$];
  int          busy_cyc;
  int          done_cyc;

  logic [10:0] exp_seq [10] = '{11'h001, 11'h002, 11'h004, 11'h008, 11'h010,
                                11'h020, 11'h040, 11'h080, 11'h100, 11'h201};

  pattern_vec_driver dut (
    .blif_clk_net   (clk),
    .blif_reset_net (rst_n),
    .start          (start),
    .seed           (seed),
    .num_vec        (num_vec),
`ifdef PATTERN_DRV_ABORT_EN
    .abort          (abort),
`endif
    .vec_out        (vec_out),
    .vec_valid      (vec_valid),
    .rsp_in         (rsp_in),
    .busy           (busy),
    .done           (done),
    .signature      (signature),
    .vec_count      (vec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [10:0] s, input logic [15:0] n);
    @(negedge clk);
    seed    = s;
    num_vec = n;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Observes one run from the cycle after start until done; optionally pulses
  // a stray start at observation cycle inject_at.
  task automatic run_collect(input int inject_at);
    vecs.delete();
    busy_cyc = 0;
    done_cyc = -1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      start = (cyc == inject_at);
      if (cyc == inject_at) begin
        seed    = 11'h7ff;
        num_vec = 16'd3;
      end
      if (vec_valid) vecs.push_back(vec_out);
      if (busy) busy_cyc++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, "_len"}, vecs.size(), 10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("%s_vec%0d", tag, i), (i < vecs.size()) ? {21'd0, vecs[i]} : 32'hdead, {21'd0, exp_seq[i]});
    end
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    seed    = '0;
    num_vec = '0;
    abort   = 1'b0;
    rsp_in  = '0;

    repeat (2) @(negedge clk);
    chk("rst_vec_out", {21'd0, vec_out}, 32'd0);
    chk("rst_vec_valid", {31'd0, vec_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_signature", {16'd0, signature}, 32'd0);
    chk("rst_vec_count", {16'd0, vec_count}, 32'd0);
    rst_n = 1'b1;

    // Basic sequence, zero responses
    pulse_start(11'h001, 16'd10);
    run_collect(-1);
    chk_seq("seq");
    chk("seq_sig", {16'd0, signature}, 32'd0);
    chk("seq_count", {16'd0, vec_count}, 32'd10);
    chk("seq_busy_cyc", busy_cyc, 12);
    chk("seq_done_cyc", done_cyc, 12);

    // MISR compaction with constant response 8'h01
    rsp_in = 8'h01;
    pulse_start(11'h001, 16'd2);
    run_collect(-1);
    chk("misr_n2", {16'd0, signature}, 32'h0003);
    pulse_start(11'h001, 16'd1);
    run_collect(-1);
    chk("misr_n1", {16'd0, signature}, 32'h0001);
    pulse_start(11'h001, 16'd3);
    run_collect(-1);
    chk("misr_n3", {16'd0, signature}, 32'h0007);
    chk("misr_n3_done_cyc", done_cyc, 5);

    // num_vec = 0: immediate done, signature cleared by start
    rsp_in = 8'h00;
    pulse_start(11'h001, 16'd0);
    run_collect(-1);
    chk("zero_done_cyc", done_cyc, 0);
    chk("zero_busy_cyc", busy_cyc, 0);
    chk("zero_sig", {16'd0, signature}, 32'd0);
    chk("zero_count", {16'd0, vec_count}, 32'd0);

    // Zero seed forced to 1
    pulse_start(11'h000, 16'd1);
    run_collect(-1);
    chk("seed0_len", vecs.size(), 1);
    chk("seed0_first", (vecs.size() > 0) ? {21'd0, vecs[0]} : 32'hdead, 32'h001);

    // Stray start in mid-RUN is ignored
    pulse_start(11'h001, 16'd10);
    run_collect(4);
    chk_seq("busy_start");
    chk("busy_start_count", {16'd0, vec_count}, 32'd10);
    chk("busy_start_busy_cyc", busy_cyc, 12);

    // Reset during RUN at vector 5
    pulse_start(11'h001, 16'd10);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (vec_count == 16'd5) break;
    end
    chk("mid_rst_reached_5", {16'd0, vec_count}, 32'd5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vec_out", {21'd0, vec_out}, 32'd0);
    chk("mid_rst_vec_valid", {31'd0, vec_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_sig", {16'd0, signature}, 32'd0);
    chk("mid_rst_count", {16'd0, vec_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start(11'h001, 16'd10);
    run_collect(-1);
    chk_seq("post_rst");
    chk("post_rst_count", {16'd0, vec_count}, 32'd10);

`ifdef PATTERN_DRV_ABORT_EN
    // Abort after vector 3; two responses already captured
    rsp_in = 8'h01;
    pulse_start(11'h001, 16'd10);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (vec_count == 16'd3) break;
    end
    chk("abort_reached_3", {16'd0, vec_count}, 32'd3);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_done", {31'd0, done}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_count", {16'd0, vec_count}, 32'd3);
    chk("abort_sig", {16'd0, signature}, 32'h0003);
    @(negedge clk);
    chk("abort_done_low", {31'd0, done}, 32'd0);
    chk("abort_sig_hold", {16'd0, signature}, 32'h0003);
    repeat (3) @(negedge clk);
    chk("abort_sig_hold2", {16'd0, signature}, 32'h0003);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
